// File: rtl/orsram_ctrl.sv
// Output SRAM array controller: sequential writes, windowed streaming reads.
// Optional read stall counter enabled by ORSRAM_CTRL_STAT_EN.
module orsram_ctrl #(
  parameter int SRAM_NUM = 8,
  parameter int ADDR_W   = 7,
  parameter int DATA_W   = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         buf_clr,
  input  logic                         wr_valid,
  output logic                         wr_ready,
  input  logic [SRAM_NUM*DATA_W-1:0]   wr_data,
  output logic [ADDR_W:0]              wr_count,
  input  logic                         rd_start,
  input  logic [ADDR_W-1:0]            rd_base,
  input  logic [ADDR_W:0]              rd_len,
  output logic                         rd_valid,
  input  logic                         rd_ready,
  output logic [SRAM_NUM*DATA_W-1:0]   rd_data,
  output logic                         rd_done,
  output logic                         busy,
`ifdef ORSRAM_CTRL_STAT_EN
  output logic [15:0]                  rd_stall_cnt,
`endif
  output logic                         sram_cen,
  output logic [SRAM_NUM-1:0]          sram_wen,
  output logic [SRAM_NUM*ADDR_W-1:0]   sram_a,
  output logic [SRAM_NUM*DATA_W-1:0]   sram_d,
  input  logic [SRAM_NUM*DATA_W-1:0]   sram_q
);

  localparam int WW = SRAM_NUM * DATA_W;
  localparam logic [ADDR_W:0] FULL = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN
  } state_t;

  state_t state, nstate;

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W:0]   wr_cnt;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W:0]   rem;
  logic              v1, v2;
  logic [WW-1:0]     fmem [2];
  logic              frp, fwp;
  logic [1:0]        fcnt;
  logic              done_q;
  logic              cen_q, wen_q;
  logic [ADDR_W-1:0] a_q;
  logic [WW-1:0]     d_q;

  logic       wr_acc, pop, push, pop_f;
  logic       issue, done_d, start_ok;
  logic [2:0] tot, lim;

  assign wr_ready = !rst && (state == IDLE) && !buf_clr
                    && !rd_start && (wr_cnt != FULL);
  assign wr_acc   = wr_valid && wr_ready;
  assign wr_count = wr_cnt;
  assign busy     = (state != IDLE);
  assign rd_done  = done_q;

  // head of buffer first; otherwise returning SRAM data bypasses the buffer
  assign rd_valid = (fcnt != 2'd0) || v2;
  assign rd_data  = (fcnt != 2'd0) ? fmem[frp] : sram_q;
  assign pop      = rd_valid && rd_ready;
  assign pop_f    = pop && (fcnt != 2'd0);
  assign push     = v2 && !(pop && (fcnt == 2'd0));

  // words owned by the buffer or still in the SRAM pipe, net of this pop
  assign tot = {1'b0, fcnt} + {2'b0, v1} + {2'b0, v2};
  assign lim = pop ? 3'd3 : 3'd2;

  assign sram_cen = cen_q;
  assign sram_wen = {SRAM_NUM{wen_q}};
  assign sram_a   = {SRAM_NUM{a_q}};
  assign sram_d   = d_q;

  always_comb begin
    nstate   = state;
    issue    = 1'b0;
    done_d   = 1'b0;
    start_ok = 1'b0;
    unique case (state)
      IDLE: begin
        if (rd_start) begin
          start_ok = 1'b1;
          if (rd_len != '0) nstate = READ;
          else              done_d = 1'b1;
        end
      end
      READ: begin
        if ((rem != '0) && (tot < lim)) begin
          issue = 1'b1;
          if (rem == {{ADDR_W{1'b0}}, 1'b1}) nstate = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && (tot == 3'd1)) begin
          nstate = IDLE;
          done_d = 1'b1;
        end
      end
      default: nstate = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      done_q <= 1'b0;
      v1     <= 1'b0;
      v2     <= 1'b0;
    end else begin
      state  <= nstate;
      done_q <= done_d;
      v1     <= issue;
      v2     <= v1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      wr_cnt <= '0;
    end else if (state == IDLE && buf_clr) begin
      wr_ptr <= '0;
      wr_cnt <= '0;
    end else if (wr_acc) begin
      wr_ptr <= wr_ptr + 1'b1;
      wr_cnt <= wr_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_addr <= '0;
      rem     <= '0;
    end else if (start_ok && rd_len != '0) begin
      rd_addr <= rd_base;
      rem     <= rd_len;
    end else if (issue) begin
      rd_addr <= rd_addr + 1'b1;
      rem     <= rem - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cen_q <= 1'b1;
      wen_q <= 1'b1;
      a_q   <= '0;
      d_q   <= '0;
    end else if (wr_acc) begin
      cen_q <= 1'b0;
      wen_q <= 1'b0;
      a_q   <= wr_ptr;
      d_q   <= wr_data;
    end else if (issue) begin
      cen_q <= 1'b0;
      wen_q <= 1'b1;
      a_q   <= rd_addr;
    end else begin
      cen_q <= 1'b1;
      wen_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frp     <= 1'b0;
      fwp     <= 1'b0;
      fcnt    <= 2'd0;
      fmem[0] <= '0;
      fmem[1] <= '0;
    end else begin
      if (push) begin
        fmem[fwp] <= sram_q;
        fwp       <= ~fwp;
      end
      if (pop_f) frp <= ~frp;
      fcnt <= fcnt + {1'b0, push} - {1'b0, pop_f};
    end
  end

`ifdef ORSRAM_CTRL_STAT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_stall_cnt <= '0;
    end else if (start_ok) begin
      rd_stall_cnt <= '0;
    end else if (rd_valid && !rd_ready && rd_stall_cnt != 16'hFFFF) begin
      rd_stall_cnt <= rd_stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_orsram_ctrl.sv
// Scoreboard bench for orsram_ctrl with a behavioural 8-bank SRAM.
// Stall counter checks compile in with ORSRAM_CTRL_STAT_EN.
module tb_orsram_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        buf_clr = 1'b0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [63:0] wr_data = '0;
  logic [7:0]  wr_count;
  logic        rd_start = 1'b0;
  logic [6:0]  rd_base = '0;
  logic [7:0]  rd_len = '0;
  logic        rd_valid;
  logic        rd_ready = 1'b0;
  logic [63:0] rd_data;
  logic        rd_done;
  logic        busy;
  logic        sram_cen;
  logic [7:0]  sram_wen;
  logic [55:0] sram_a;
  logic [63:0] sram_d;
  logic [63:0] sram_q = '0;
`ifdef ORSRAM_CTRL_STAT_EN
  logic [15:0] rd_stall_cnt;
`endif

  orsram_ctrl dut (
    .clk(clk),
    .rst(rst),
    .buf_clr(buf_clr),
    .wr_valid(wr_valid),
    .wr_ready(wr_ready),
    .wr_data(wr_data),
    .wr_count(wr_count),
    .rd_start(rd_start),
    .rd_base(rd_base),
    .rd_len(rd_len),
    .rd_valid(rd_valid),
    .rd_ready(rd_ready),
    .rd_data(rd_data),
    .rd_done(rd_done),
    .busy(busy),
`ifdef ORSRAM_CTRL_STAT_EN
    .rd_stall_cnt(rd_stall_cnt),
`endif
    .sram_cen(sram_cen),
    .sram_wen(sram_wen),
    .sram_a(sram_a),
    .sram_d(sram_d),
    .sram_q(sram_q)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [8][128];

  always @(posedge clk) begin
    for (int i = 0; i < 8; i++) begin
      if (!sram_cen) begin
        if (!sram_wen[i])
          mem[i][sram_a[i*7 +: 7]] <= sram_d[i*8 +: 8];
        else
          sram_q[i*8 +: 8] <= mem[i][sram_a[i*7 +: 7]];
      end
    end
  end

  typedef struct {
    logic [6:0]  a;
    logic [63:0] d;
  } wexp_t;

  wexp_t       wq[$];
  logic [6:0]  raq[$];
  logic [63:0] rdq[$];
  logic [63:0] shadow [128];
  logic [6:0]  m_ptr = '0;
  int          m_cnt = 0;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int beats = 0;
  int stalls = 0;
  int last_acc = 0;
  int first_acc = -1;
  int first_val = -1;
  bit prev_stall = 1'b0;
  logic [63:0] prev_data = '0;
  wexp_t e;
  logic [63:0] exp_d;
  logic [6:0]  exp_a;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (!sram_cen && sram_wen == 8'h00) begin
        if (wq.size() != 0) begin
          e = wq.pop_front();
          chk("wr_addr", 64'(sram_a), 64'({8{e.a}}));
          chk("wr_data", sram_d, e.d);
        end else begin
          chk("wr_unexp", 64'(wq.size()), 64'd1);
        end
      end else if (!sram_cen && sram_wen == 8'hFF) begin
        if (first_acc < 0) first_acc = cyc;
        if (raq.size() != 0) begin
          exp_a = raq.pop_front();
          chk("rd_addr", 64'(sram_a), 64'({8{exp_a}}));
        end else begin
          chk("rd_unexp", 64'(raq.size()), 64'd1);
        end
      end
      if (rd_valid) begin
        if (first_val < 0) first_val = cyc;
        if (prev_stall) chk("rd_hold", rd_data, prev_data);
      end
      if (rd_valid && rd_ready) begin
        beats++;
        last_acc = cyc;
        if (rdq.size() != 0) begin
          exp_d = rdq.pop_front();
          chk("rd_data", rd_data, exp_d);
        end else begin
          chk("rd_extra", 64'(rdq.size()), 64'd1);
        end
      end
      if (rd_valid && !rd_ready) stalls++;
      prev_stall = rd_valid && !rd_ready;
      prev_data  = rd_data;
    end
  end

  task automatic wr(input logic [63:0] w);
    bit acc;
    acc = (m_cnt != 128);
    wr_valid = 1'b1;
    wr_data  = w;
    @(negedge clk); #1;
    chk("wr_ready", 64'(wr_ready), 64'(acc));
    if (acc) begin
      wq.push_back('{a: m_ptr, d: w});
      shadow[m_ptr] = w;
      m_ptr++;
      m_cnt++;
    end
    @(posedge clk); #1;
    wr_valid = 1'b0;
  endtask

  task automatic chk_reset_outs();
    chk("rst_wr_ready", 64'(wr_ready), 64'd0);
    chk("rst_wr_count", 64'(wr_count), 64'd0);
    chk("rst_rd_valid", 64'(rd_valid), 64'd0);
    chk("rst_rd_done", 64'(rd_done), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_cen", 64'(sram_cen), 64'd1);
    chk("rst_wen", 64'(sram_wen), 64'hFF);
    chk("rst_a", 64'(sram_a), 64'd0);
    chk("rst_d", sram_d, 64'd0);
`ifdef ORSRAM_CTRL_STAT_EN
    chk("rst_stall", 64'(rd_stall_cnt), 64'd0);
`endif
  endtask

  task automatic rd(input logic [6:0] base, input logic [7:0] len,
                    input logic [3:0] pat, input int abort_at,
                    input bit with_wr);
    int start_cyc;
    int k;
    bit got_done;
    rd_start  = 1'b1;
    rd_base   = base;
    rd_len    = len;
    wr_valid  = with_wr;
    wr_data   = 64'hDEAD_BEEF_0BAD_F00D;
    rd_ready  = pat[0];
    stalls    = 0;
    beats     = 0;
    first_acc = -1;
    first_val = -1;
    for (int i = 0; i < int'(len); i++) begin
      raq.push_back(7'(int'(base) + i));
      rdq.push_back(shadow[7'(int'(base) + i)]);
    end
    @(negedge clk); #1;
    chk("wr_rdy_rdstart", 64'(wr_ready), 64'd0);
    start_cyc = cyc;
    @(posedge clk); #1;
    rd_start = 1'b0;
    wr_valid = 1'b0;
    got_done = 1'b0;
    k = 1;
    for (int t = 0; t < 200 && !got_done; t++) begin
      rd_ready = pat[k % 4];
      k++;
      @(negedge clk); #1;
      if (abort_at > 0 && beats >= abort_at) begin
        rst = 1'b1;
        #1;
        chk_reset_outs();
        rdq.delete();
        raq.delete();
        wq.delete();
        m_ptr = '0;
        m_cnt = 0;
        rd_ready = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        return;
      end
      if (rd_done) begin
        got_done = 1'b1;
        chk("done_cyc", 64'(cyc),
            64'(len == 0 ? start_cyc + 1 : last_acc + 1));
        chk("busy_done", 64'(busy), 64'd0);
        if (len == 0) chk("len0_cen", 64'(sram_cen), 64'd1);
      end
      @(posedge clk); #1;
    end
    rd_ready = 1'b0;
    chk("done_seen", 64'(got_done), 64'd1);
    chk("rdq_left", 64'(rdq.size()), 64'd0);
    chk("raq_left", 64'(raq.size()), 64'd0);
  endtask

  initial begin
    for (int a = 0; a < 128; a++) begin
      shadow[a] = '0;
      for (int b = 0; b < 8; b++) mem[b][a] = '0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk_reset_outs();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk); #1;
    chk("idle_wr_ready", 64'(wr_ready), 64'd1);
    @(posedge clk); #1;

    wr(64'h0101_0101_0101_0101);
    wr(64'h0202_0202_0202_0202);
    wr(64'h0303_0303_0303_0303);
    repeat (2) @(posedge clk);
    #1;
    chk("wr_count3", 64'(wr_count), 64'd3);

    rd(7'd0, 8'd3, 4'hF, 0, 1'b0);
    chk("rd_latency", 64'(first_val - first_acc), 64'd1);

    for (int i = 0; i < 125; i++) wr({$urandom, $urandom});
    wr(64'h1290_1290_1290_1290);
    repeat (2) @(posedge clk);
    #1;
    chk("wr_count_full", 64'(wr_count), 64'd128);

    rd(7'd126, 8'd4, 4'hF, 0, 1'b0);

    rd(7'd10, 8'd4, 4'b1001, 0, 1'b0);
`ifdef ORSRAM_CTRL_STAT_EN
    chk("stall_cnt", 64'(rd_stall_cnt), 64'(stalls));
`endif

    rd(7'd5, 8'd0, 4'hF, 0, 1'b1);
    chk("wr_count_len0", 64'(wr_count), 64'd128);

    buf_clr  = 1'b1;
    wr_valid = 1'b1;
    @(negedge clk); #1;
    chk("clr_wr_ready", 64'(wr_ready), 64'd0);
    @(posedge clk); #1;
    buf_clr  = 1'b0;
    wr_valid = 1'b0;
    m_ptr = '0;
    m_cnt = 0;
    @(negedge clk); #1;
    chk("clr_wr_count", 64'(wr_count), 64'd0);
    @(posedge clk); #1;

    rd(7'd0, 8'd5, 4'hF, 2, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rd(7'd0, 8'd5, 4'hF, 0, 1'b0);
    chk("wr_count_end", 64'(wr_count), 64'(m_cnt));

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
